// File: rtl/serdiv_mr_pkg.sv
// Shared types for the multi-bit restoring divider: core config subset,
// divider opcodes and FSM state encoding.
package serdiv_mr_pkg;

  typedef struct packed {
    int unsigned TRANS_ID_BITS;
    int unsigned NUM_THREADS;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{TRANS_ID_BITS: 32'd3, NUM_THREADS: 32'd2};

  typedef enum logic [1:0] {
    DIV_UDIV = 2'd0,
    DIV_DIV  = 2'd1,
    DIV_UREM = 2'd2,
    DIV_REM  = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_DONE   = 2'd2
  } div_state_e;

endpackage

// File: rtl/serdiv_mr_step.sv
// Combinational core of the divider: STEP chained restoring stages applied
// to the {remainder, quotient/dividend} pair against an unsigned divisor.
module serdiv_mr_step #(
  parameter int WIDTH = 64,
  parameter int STEP  = 2
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH:0]   w_trial;

  // Each stage shifts the next dividend bit into the partial remainder and
  // keeps the difference only when the trial subtraction does not borrow.
  // The trial value is one bit wider because 2*rem+1 can exceed WIDTH bits.
  always_comb begin
    w_rem   = i_rem;
    w_quot  = i_quot;
    w_trial = '0;
    for (int k = 0; k < STEP; k++) begin
      w_trial = {w_rem, w_quot[WIDTH-1]};
      w_quot  = {w_quot[WIDTH-2:0], 1'b0};
      if (w_trial >= {1'b0, i_div}) begin
        w_trial   = w_trial - {1'b0, i_div};
        w_quot[0] = 1'b1;
      end
      w_rem = w_trial[WIDTH-1:0];
    end
  end

  assign o_rem  = w_rem;
  assign o_quot = w_quot;

endmodule

// File: rtl/serdiv_mr.sv
// Serial restoring divider resolving STEP quotient bits per clock, with
// native RV64 word ops, fixed iteration count and divide-by-zero early-out.
//
// state    | meaning
// S_IDLE   | ready for a new op; in_rdy_o=1
// S_DIVIDE | iterating; counter counts down to 0 on the last update
// S_DONE   | result presented with out_vld_o=1 until out_rdy_i
module serdiv_mr
  import serdiv_mr_pkg::*;
#(
  parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty,
  parameter int        WIDTH   = 64,
  parameter int        STEP    = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [CVA6Cfg.TRANS_ID_BITS-1:0]        id_i,
  input  logic [$clog2(CVA6Cfg.NUM_THREADS)-1:0]  thread_id_i,
  input  logic [WIDTH-1:0]                        op_a_i,
  input  logic [WIDTH-1:0]                        op_b_i,
  input  logic [1:0]                              opcode_i,
  input  logic                                    word_i,
  input  logic                                    in_vld_i,
  output logic                                    in_rdy_o,
  input  logic                                    flush_i,
  output logic                                    out_vld_o,
  input  logic                                    out_rdy_i,
  output logic [CVA6Cfg.TRANS_ID_BITS-1:0]        id_o,
  output logic [$clog2(CVA6Cfg.NUM_THREADS)-1:0]  thread_id_o,
  output logic [WIDTH-1:0]                        res_o
);

  localparam int SH    = WIDTH - 32;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH / STEP - 1);
  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(32 / STEP - 1);

  // Extend bit 31 upward (or zero-fill when sx=0); identity when WIDTH=32.
  function automatic logic [WIDTH-1:0] ext32(input logic [WIDTH-1:0] v, input logic sx);
    logic [WIDTH-1:0] r;
    r = v;
    for (int k = 32; k < WIDTH; k++) r[k] = sx & v[31];
    return r;
  endfunction

  div_state_e r_state, w_state_d;

  logic [WIDTH-1:0] r_rem, r_quot, r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q, r_neg_r, r_rem_sel, r_word;
  logic [CVA6Cfg.TRANS_ID_BITS-1:0]       r_id;
  logic [$clog2(CVA6Cfg.NUM_THREADS)-1:0] r_tid;

  div_op_e          w_op;
  logic             w_signed, w_rem_sel, w_a_neg, w_b_neg, w_b_zero, w_accept;
  logic [WIDTH-1:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs;
  logic [WIDTH-1:0] w_rem_nx, w_quot_nx, w_q_fix, w_r_fix, w_res_raw;

  assign w_op      = div_op_e'(opcode_i);
  assign w_signed  = (w_op == DIV_DIV) || (w_op == DIV_REM);
  assign w_rem_sel = (w_op == DIV_UREM) || (w_op == DIV_REM);
  // After extension the MSB is the operand sign for both widths.
  assign w_a_ext   = word_i ? ext32(op_a_i, w_signed) : op_a_i;
  assign w_b_ext   = word_i ? ext32(op_b_i, w_signed) : op_b_i;
  assign w_a_neg   = w_signed & w_a_ext[WIDTH-1];
  assign w_b_neg   = w_signed & w_b_ext[WIDTH-1];
  assign w_a_abs   = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_abs   = w_b_neg ? -w_b_ext : w_b_ext;
  assign w_b_zero  = (w_b_ext == '0);
  assign w_accept  = (r_state == S_IDLE) && in_vld_i && !flush_i;

  serdiv_mr_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .i_rem  (r_rem),
    .i_quot (r_quot),
    .i_div  (r_div),
    .o_rem  (w_rem_nx),
    .o_quot (w_quot_nx)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_d;
  end

  // Next-state logic; flush overrides everything, including a pending accept.
  always_comb begin
    w_state_d = r_state;
    if (flush_i) begin
      w_state_d = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (in_vld_i) w_state_d = w_b_zero ? S_DONE : S_DIVIDE;
        S_DIVIDE: if (r_cnt == '0) w_state_d = S_DONE;
        S_DONE:   if (out_rdy_i) w_state_d = S_IDLE;
        default:  w_state_d = S_IDLE;
      endcase
    end
  end

  // Operand capture on accept and iteration while dividing.
  // Word dividends are parked in the upper half so 32 shifts consume them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rem     <= '0;
      r_quot    <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem_sel <= 1'b0;
      r_word    <= 1'b0;
      r_id      <= '0;
      r_tid     <= '0;
    end else if (w_accept) begin
      r_rem_sel <= w_rem_sel;
      r_word    <= word_i;
      r_id      <= id_i;
      r_tid     <= thread_id_i;
      r_div     <= w_b_abs;
      r_cnt     <= word_i ? CNT_WORD : CNT_FULL;
      if (w_b_zero) begin
        r_quot  <= '1;
        r_rem   <= w_a_ext;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else begin
        r_quot  <= word_i ? (w_a_abs << SH) : w_a_abs;
        r_rem   <= '0;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end
    end else if (r_state == S_DIVIDE) begin
      r_rem  <= w_rem_nx;
      r_quot <= w_quot_nx;
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  assign w_q_fix   = r_neg_q ? -r_quot : r_quot;
  assign w_r_fix   = r_neg_r ? -r_rem : r_rem;
  assign w_res_raw = r_rem_sel ? w_r_fix : w_q_fix;

  // Handshake flags and result formatting from the registered state.
  always_comb begin
    in_rdy_o  = (r_state == S_IDLE);
    out_vld_o = (r_state == S_DONE);
    res_o     = r_word ? ext32(w_res_raw, 1'b1) : w_res_raw;
  end

  assign id_o        = r_id;
  assign thread_id_o = r_tid;

  a_step_legal: assert property (@(posedge clk_i)
    (STEP == 1 || STEP == 2 || STEP == 4) && (WIDTH == 32 || WIDTH == 64));
  a_word_legal: assert property (@(posedge clk_i)
    !(in_vld_i && word_i && (WIDTH == 32)));
  a_out_stable: assert property (@(posedge clk_i)
    (out_vld_o && !out_rdy_i && !flush_i && !rst_i) |=>
    (out_vld_o && $stable(res_o) && $stable(id_o) && $stable(thread_id_o)));

endmodule

// File: tb/tb_serdiv_mr.sv
// Scoreboard bench for serdiv_mr (WIDTH=64, STEP=2): a driver pushes the
// reference result on each accept, a monitor checks every presented result.
module tb_serdiv_mr;

  localparam int STEP_TB = 2;

  typedef struct {
    logic [63:0] res;
    logic [2:0]  id;
    logic        tid;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk_i;
  logic        rst_i;
  logic [2:0]  id_i;
  logic [0:0]  thread_id_i;
  logic [63:0] op_a_i, op_b_i;
  logic [1:0]  opcode_i;
  logic        word_i, in_vld_i, in_rdy_o, flush_i, out_vld_o, out_rdy_i;
  logic [2:0]  id_o;
  logic [0:0]  thread_id_o;
  logic [63:0] res_o;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   rdy_hold = 0;
  bit   rdy_rand = 0;
  exp_t sb_q[$];

  serdiv_mr #(.WIDTH(64), .STEP(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .id_i        (id_i),
    .thread_id_i (thread_id_i),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .opcode_i    (opcode_i),
    .word_i      (word_i),
    .in_vld_i    (in_vld_i),
    .in_rdy_o    (in_rdy_o),
    .flush_i     (flush_i),
    .out_vld_o   (out_vld_o),
    .out_rdy_i   (out_rdy_i),
    .id_o        (id_o),
    .thread_id_o (thread_id_o),
    .res_o       (res_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // RISC-V division semantics straight from the ISA rules.
  function automatic logic [63:0] ref_res(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] op, input logic word);
    logic sgn, rem;
    sgn = op[0];
    rem = op[1];
    if (word) begin
      logic [31:0] ua, ub, r32;
      int sa, sb;
      ua = a[31:0];
      ub = b[31:0];
      sa = ua;
      sb = ub;
      if (ub == 0)                                             r32 = rem ? ua : 32'hFFFF_FFFF;
      else if (sgn && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = rem ? 32'h0 : ua;
      else if (sgn)                                            r32 = rem ? sa % sb : sa / sb;
      else                                                     r32 = rem ? ua % ub : ua / ub;
      return {{32{r32[31]}}, r32};
    end else begin
      longint sa, sb;
      sa = a;
      sb = b;
      if (b == 0)                                                          return rem ? a : '1;
      if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return rem ? 64'h0 : a;
      if (sgn) return rem ? sa % sb : sa / sb;
      return rem ? a % b : a / b;
    end
  endfunction

  function automatic int ref_lat(input logic [63:0] b, input logic word);
    if (word ? (b[31:0] == 32'h0) : (b == 64'h0)) return 1;
    return (word ? 32 : 64) / STEP_TB + 1;
  endfunction

  // Presents one op from the posedge+2 phase until accepted; returns at posedge+2.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                       input logic word, input logic [2:0] id, input logic tid);
    exp_t e;
    bit   done;
    int   guard;
    done = 0;
    guard = 0;
    op_a_i = a; op_b_i = b; opcode_i = op; word_i = word;
    id_i = id; thread_id_i = tid; in_vld_i = 1'b1;
    while (!done) begin
      @(negedge clk_i);
      if (in_rdy_o && !flush_i && !rst_i) begin
        e.res = ref_res(a, b, op, word);
        e.id  = id;
        e.tid = tid;
        e.acc = cyc + 1;
        e.lat = ref_lat(b, word);
        sb_q.push_back(e);
        done = 1;
      end else if (++guard > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_rdy_o stayed 0 for %0d cycles, expected 1", guard);
        done = 1;
      end
      @(posedge clk_i); #2;
    end
    in_vld_i = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    do begin
      @(negedge clk_i);
      guard++;
    end while ((sb_q.size() != 0 || !in_rdy_o) && guard < 400);
    if (guard >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
    end
    @(posedge clk_i); #2;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_out_vld"}, 64'(out_vld_o), 64'd0);
    chk({tag, "_res"}, res_o, 64'd0);
    chk({tag, "_id"}, 64'(id_o), 64'd0);
    chk({tag, "_tid"}, 64'(thread_id_o), 64'd0);
    chk({tag, "_in_rdy"}, 64'(in_rdy_o), 64'd1);
  endtask

  // Consumer ready: forced low, randomised, or always high.
  initial begin
    out_rdy_i = 1'b1;
    forever begin
      @(posedge clk_i); #2;
      out_rdy_i = rdy_hold ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: every cycle a result is shown it must match the head expectation.
  initial begin
    bit   prev;
    int   lat;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i || flush_i) begin
        prev = 0;
      end else if (out_vld_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_vld: got res 0x%h, expected no result", res_o);
        end else begin
          e = sb_q[0];
          if (!prev) begin
            lat = cyc - e.acc + 1;
            chk("latency", 64'(lat), 64'(e.lat));
          end
          chk("res", res_o, e.res);
          chk("id", 64'(id_o), 64'(e.id));
          chk("thread_id", 64'(thread_id_o), 64'(e.tid));
          if (out_rdy_i) void'(sb_q.pop_front());
        end
        prev = 1;
      end else begin
        prev = 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    rst_i = 1'b1; flush_i = 1'b0; in_vld_i = 1'b0;
    op_a_i = '0; op_b_i = '0; opcode_i = '0; word_i = 1'b0; id_i = '0; thread_id_i = '0;
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    reset_vals("reset");
    @(posedge clk_i); #2;

    issue(64'd100, 64'd7, 2'd0, 1'b0, 3'd1, 1'b0);
    issue(64'd100, 64'd7, 2'd2, 1'b0, 3'd2, 1'b1);
    issue(-64'd7, 64'd2, 2'd1, 1'b0, 3'd3, 1'b0);
    issue(-64'd7, 64'd2, 2'd3, 1'b0, 3'd4, 1'b1);
    issue(64'h8000_0000_0000_0000, '1, 2'd1, 1'b0, 3'd5, 1'b0);
    issue(64'h8000_0000_0000_0000, '1, 2'd3, 1'b0, 3'd6, 1'b1);
    issue(64'd42, 64'd0, 2'd0, 1'b0, 3'd7, 1'b0);
    issue(64'd42, 64'd0, 2'd2, 1'b0, 3'd0, 1'b1);
    issue(-64'd5, 64'd0, 2'd3, 1'b0, 3'd1, 1'b0);
    issue(64'h1_8000_0000, 64'd1, 2'd0, 1'b1, 3'd2, 1'b1);
    issue(64'h1234_5678_FFFF_FFF7, 64'h9_0000_0004, 2'd3, 1'b1, 3'd3, 1'b0);
    issue(64'h0000_0001_8000_0000, 64'h7_FFFF_FFFF, 2'd1, 1'b1, 3'd4, 1'b1);
    issue(64'hABCD_0000_0000_0123, 64'h1_0000_0000, 2'd3, 1'b1, 3'd5, 1'b0);
    drain();

    // Backpressure: result must hold while the consumer stalls.
    #0 rdy_hold = 1'b1;
    @(posedge clk_i); #2;
    issue(64'd100, 64'd7, 2'd0, 1'b0, 3'd3, 1'b1);
    guard = 0;
    do begin
      @(negedge clk_i);
      guard++;
    end while (!out_vld_o && guard < 60);
    chk("bp_out_vld_seen", 64'(out_vld_o), 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_in_rdy", 64'(in_rdy_o), 64'd0);
      chk("bp_out_vld", 64'(out_vld_o), 64'd1);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    rdy_hold = 1'b0;
    @(negedge clk_i);
    chk("bp_release_vld", 64'(out_vld_o), 64'd1);
    @(negedge clk_i);
    chk("bp_idle_in_rdy", 64'(in_rdy_o), 64'd1);
    chk("bp_idle_out_vld", 64'(out_vld_o), 64'd0);
    @(posedge clk_i); #2;

    // Flush mid-divide, then flush with a simultaneous valid in IDLE.
    issue(64'd1000, 64'd3, 2'd0, 1'b0, 3'd6, 1'b0);
    repeat (5) @(posedge clk_i);
    #2 flush_i = 1'b1;
    sb_q.delete();
    @(posedge clk_i); #2;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_in_rdy", 64'(in_rdy_o), 64'd1);
    chk("flush_out_vld", 64'(out_vld_o), 64'd0);
    @(posedge clk_i); #2;
    op_a_i = 64'd77; op_b_i = 64'd3; opcode_i = 2'd0; word_i = 1'b0;
    in_vld_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #2;
    in_vld_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_accept_suppressed", 64'(in_rdy_o), 64'd1);
    @(posedge clk_i); #2;
    issue(64'd6, 64'd3, 2'd0, 1'b0, 3'd5, 1'b1);
    drain();

    // Reset mid-divide: no result, registers cleared.
    issue(64'd999, 64'd4, 2'd2, 1'b0, 3'd7, 1'b1);
    repeat (5) @(posedge clk_i);
    #2 rst_i = 1'b1;
    sb_q.delete();
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    @(negedge clk_i);
    reset_vals("midreset");
    @(posedge clk_i); #2;
    issue(64'd6, 64'd3, 2'd0, 1'b0, 3'd5, 1'b0);
    drain();

    // Randomised traffic with random consumer stalls.
    rdy_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [63:0] a, b;
      logic [1:0]  op;
      logic        w;
      int          sel;
      op  = 2'($urandom_range(0, 3));
      w   = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 5);
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      case (sel)
        0: begin a = 64'($urandom_range(0, 200)); b = 64'($urandom_range(1, 15)); end
        1: ;
        2: b = w ? {b[63:32], 32'h0} : 64'h0;
        3: begin a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000; b = '1; end
        4: b = 64'($urandom_range(1, 1000));
        default: begin
          a = -64'($urandom_range(1, 500));
          b = 64'($urandom_range(1, 9));
          if ($urandom_range(0, 1) == 1) b = -b;
        end
      endcase
      issue(a, b, op, w, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    rdy_rand = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
